// File: rtl/fifo_slot_alloc.sv
// rtl/fifo_slot_alloc.sv - round-robin buffer slot allocator over a circular free list.
// Optional illegal-free tracking with FIFO_SLOT_ALLOC_CHECK_EN.
module fifo_slot_alloc #(
  parameter int DEPTH  = 4,
  parameter int PTR_SZ = 2,
  parameter int N_REQ  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  alloc_req,
  output logic [N_REQ-1:0]  alloc_gnt,
  output logic [PTR_SZ-1:0] alloc_idx,
  input  logic              free_en,
  input  logic [PTR_SZ-1:0] free_idx,
  output logic [PTR_SZ:0]   free_cnt,
  output logic              empty,
  output logic              full,
  output logic              err_free
);

  localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_SZ:0] FULL_CNT = (PTR_SZ+1)'(DEPTH);
  localparam logic [PTR_SZ:0] ONE_CNT  = (PTR_SZ+1)'(1);

  logic [PTR_SZ-1:0] entry [DEPTH];
  logic [PTR_SZ-1:0] rd_ptr;
  logic [PTR_SZ-1:0] wr_ptr;
  logic [PTR_SZ:0]   count;
  logic [RR_W-1:0]   rr_ptr;

  logic              win_found;
  logic [RR_W-1:0]   win_k;
  logic [RR_W-1:0]   cand;
  int                sum;
  logic              alloc_fire;
  logic              free_fire;
  logic [PTR_SZ-1:0] head;

  function automatic logic [PTR_SZ-1:0] ptr_inc(input logic [PTR_SZ-1:0] p);
    return (p == PTR_SZ'(DEPTH-1)) ? '0 : p + PTR_SZ'(1);
  endfunction

  // Round-robin search: first requesting port at or after rr_ptr, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_k     = '0;
    cand      = '0;
    sum       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = int'(rr_ptr) + i;
      if (sum >= N_REQ) sum = sum - N_REQ;
      cand = RR_W'(sum);
      if (!win_found && alloc_req[cand]) begin
        win_found = 1'b1;
        win_k     = cand;
      end
    end
  end

  assign head       = entry[rd_ptr];
  assign alloc_fire = win_found && (count != '0);

`ifdef FIFO_SLOT_ALLOC_CHECK_EN
  logic [DEPTH-1:0] in_use;
  logic             err_q;
  logic             idx_ok;

  // Only slots currently owned by a packet may come back; anything else is an error.
  assign idx_ok    = ({1'b0, free_idx} < FULL_CNT);
  assign free_fire = free_en && idx_ok && in_use[free_idx];
  assign err_free  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_use <= '0;
      err_q  <= 1'b0;
    end else begin
      if (alloc_fire) in_use[head] <= 1'b1;
      if (free_fire) in_use[free_idx] <= 1'b0;
      if (free_en && !free_fire) err_q <= 1'b1;
    end
  end
`else
  assign free_fire = free_en && (count != FULL_CNT);
  assign err_free  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= PTR_SZ'(i);
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= FULL_CNT;
      rr_ptr    <= '0;
      alloc_gnt <= '0;
      alloc_idx <= '0;
    end else begin
      if (alloc_fire) begin
        alloc_gnt <= N_REQ'(1) << win_k;
        alloc_idx <= head;
        rd_ptr    <= ptr_inc(rd_ptr);
        rr_ptr    <= (win_k == RR_W'(N_REQ-1)) ? '0 : win_k + RR_W'(1);
      end else begin
        alloc_gnt <= '0;
      end
      if (free_fire) begin
        entry[wr_ptr] <= free_idx;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      unique case ({alloc_fire, free_fire})
        2'b10:   count <= count - ONE_CNT;
        2'b01:   count <= count + ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  assign free_cnt = count;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);

endmodule

// File: tb/tb_fifo_slot_alloc.sv
// tb/tb_fifo_slot_alloc.sv - queue-model checker plus directed vectors for fifo_slot_alloc.
module tb_fifo_slot_alloc;
  localparam int DEPTH  = 4;
  localparam int PTR_SZ = 2;
  localparam int N_REQ  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_REQ-1:0]  alloc_req = '0;
  logic [N_REQ-1:0]  alloc_gnt;
  logic [PTR_SZ-1:0] alloc_idx;
  logic              free_en = 1'b0;
  logic [PTR_SZ-1:0] free_idx = '0;
  logic [PTR_SZ:0]   free_cnt;
  logic              empty;
  logic              full;
  logic              err_free;

  int errors = 0;
  int checks = 0;

  fifo_slot_alloc #(.DEPTH(DEPTH), .PTR_SZ(PTR_SZ), .N_REQ(N_REQ)) dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_idx(alloc_idx), .free_en(free_en), .free_idx(free_idx),
    .free_cnt(free_cnt), .empty(empty), .full(full), .err_free(err_free)
  );

  always #5 clk = ~clk;

  // Reference: free list is a plain queue, ownership a bit per slot.
  int q[$];
  int m_rr = 0;
  int m_gnt = 0;
  int m_idx = 0;
  int m_err = 0;
  bit m_inuse [DEPTH];
  bit m_valid = 0;

  always @(posedge clk) begin
    int win;
    bit ok;
    if (rst) begin
      q.delete();
      for (int i = 0; i < DEPTH; i++) begin q.push_back(i); m_inuse[i] = 0; end
      m_rr = 0; m_gnt = 0; m_idx = 0; m_err = 0;
    end else begin
      win = -1;
      if (q.size() > 0)
        for (int i = 0; i < N_REQ; i++)
          if (win < 0 && alloc_req[(m_rr + i) % N_REQ]) win = (m_rr + i) % N_REQ;
`ifdef FIFO_SLOT_ALLOC_CHECK_EN
      ok = free_en && (int'(free_idx) < DEPTH) && m_inuse[free_idx];
      if (free_en && !ok) m_err = 1;
`else
      ok = free_en && (q.size() < DEPTH);
`endif
      if (win >= 0) begin
        m_idx = q.pop_front();
        m_gnt = 1 << win;
        m_rr = (win + 1) % N_REQ;
        m_inuse[m_idx] = 1;
      end else begin
        m_gnt = 0;
      end
      if (ok) begin
        q.push_back(int'(free_idx));
        m_inuse[free_idx] = 0;
      end
    end
    m_valid = 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_gnt", int'(alloc_gnt), m_gnt);
      chk("model_idx", int'(alloc_idx), m_idx);
      chk("model_cnt", int'(free_cnt), q.size());
      chk("model_empty", int'(empty), int'(q.size() == 0));
      chk("model_full", int'(full), int'(q.size() == DEPTH));
      chk("model_err", int'(err_free), m_err);
    end
  end

  task automatic step(input logic [N_REQ-1:0] req, input logic fe, input int fi);
    alloc_req = req;
    free_en   = fe;
    free_idx  = PTR_SZ'(fi);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step('0, 1'b0, 0);
    step('0, 1'b0, 0);
    rst = 1'b0;
  endtask

  int exp_err;

  initial begin
`ifdef FIFO_SLOT_ALLOC_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    do_reset();
    chk("rst_gnt", int'(alloc_gnt), 0);
    chk("rst_idx", int'(alloc_idx), 0);
    chk("rst_cnt", int'(free_cnt), 4);
    chk("rst_full", int'(full), 1);
    chk("rst_empty", int'(empty), 0);
    chk("rst_err", int'(err_free), 0);

    // Port 0 drains the list in order.
    for (int i = 0; i < 4; i++) begin
      step(4'b0001, 1'b0, 0);
      chk("drain_gnt", int'(alloc_gnt), 1);
      chk("drain_idx", int'(alloc_idx), i);
      chk("drain_cnt", int'(free_cnt), 3 - i);
    end
    chk("drain_empty", int'(empty), 1);
    step(4'b0001, 1'b0, 0);
    chk("drain_5th_gnt", int'(alloc_gnt), 0);

    // Free at empty is not bypassed into a grant.
    step(4'b0010, 1'b1, 2);
    chk("nobypass_gnt", int'(alloc_gnt), 0);
    chk("nobypass_cnt", int'(free_cnt), 1);
    step(4'b0010, 1'b0, 0);
    chk("freed_gnt", int'(alloc_gnt), 2);
    chk("freed_idx", int'(alloc_idx), 2);

    // count==1: concurrent allocate and free keep count steady.
    step(4'b0000, 1'b1, 1);
    step(4'b0001, 1'b1, 0);
    chk("concur_idx", int'(alloc_idx), 1);
    chk("concur_cnt", int'(free_cnt), 1);
    step(4'b0001, 1'b0, 0);
    chk("concur_next_idx", int'(alloc_idx), 0);
    chk("concur_next_cnt", int'(free_cnt), 0);

    // Refill: list order becomes 3,2,1,0.
    for (int i = 3; i >= 0; i--) step(4'b0000, 1'b1, i);
    chk("refill_full", int'(full), 1);
    step(4'b0100, 1'b0, 0);
    chk("head3_idx", int'(alloc_idx), 3);
    step(4'b0000, 1'b1, 3);
    chk("ret3_cnt", int'(free_cnt), 4);
    step(4'b0000, 1'b1, 3);
    chk("dbl_free_cnt", int'(free_cnt), 4);
    chk("dbl_free_err", int'(err_free), exp_err);
    step(4'b0000, 1'b0, 0);

    // All ports requesting continuously.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 1'b0, 0);
      chk("rr_gnt", int'(alloc_gnt), 1 << i);
      chk("rr_idx", int'(alloc_idx), i);
    end
    step(4'b1111, 1'b1, 0);
    chk("rr_empty_gnt", int'(alloc_gnt), 0);
    step(4'b1111, 1'b0, 0);
    chk("rr_wrap_gnt", int'(alloc_gnt), 1);

    // Reset mid-operation.
    do_reset();
    step(4'b1111, 1'b0, 0);
    step(4'b1111, 1'b0, 0);
    chk("pre_rst_idx", int'(alloc_idx), 1);
    rst = 1'b1;
    step(4'b1111, 1'b0, 0);
    chk("midrst_gnt", int'(alloc_gnt), 0);
    chk("midrst_cnt", int'(free_cnt), 4);
    chk("midrst_full", int'(full), 1);
    rst = 1'b0;
    step(4'b1111, 1'b0, 0);
    chk("postrst_gnt", int'(alloc_gnt), 1);
    chk("postrst_idx", int'(alloc_idx), 0);
    step(4'b0000, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
